axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_ram_mem.sv | 43 ++++
 rtl/axi_ram_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the RAM slave.
// Holds the response codes, the FSM encodings and the address range check.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } w_state_e;

  // Decode errors take priority over protocol (SLVERR) errors.
  function automatic logic [1:0] resp_code(
    input logic [31:0] addr,
    input logic        bad,
    input int unsigned words
  );
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    if (idx >= words) return RESP_DECERR;
    if (bad)          return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Byte-enable RAM with one registered read port and one write port.
// A read and a write to the same word in one cycle return the old data.
module axi_ram_mem #(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Only the output register resets; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_ram_slave.sv
// Single-beat AXI4 RAM slave with independent read and write channels.
// Reads return after RD_LAT cycles; writes commit once AW and W are both seen.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic unused_inputs;
  assign unused_inputs = ^{arsize, arburst, awsize, awburst,
                           wid, araddr[1:0], awaddr[1:0]};

  // Read channel
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [3:0]  rid_q, rid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [AW-1:0] r_idx_q, r_idx_d;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    r_idx_d   = r_idx_q;
    mem_rd_en = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_state_d = R_WAIT;
          r_cnt_d   = 4'(RD_LAT - 1);
          rid_d     = arid;
          r_idx_d   = araddr[AW+1:2];
          rresp_d   = resp_code(araddr, arlen != 8'd0, MEM_WORDS);
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          r_state_d = R_RESP;
          mem_rd_en = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      r_idx_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      r_idx_q   <= r_idx_d;
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rlast   = rvalid;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rdata   = (rresp_q == RESP_DECERR) ? 32'd0 : mem_rd_data;

  // Write channel
  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [3:0]  awid_q, awid_d;
  logic [AW-1:0] aw_idx_q, aw_idx_d;
  logic [1:0]  aw_code_q, aw_code_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wlast_q, wlast_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs;
  logic        mem_we;
  logic [1:0]  w_code;

  assign awready = (w_state_q == W_COLLECT) && !aw_held_q;
  assign wready  = (w_state_q == W_COLLECT) && !w_held_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awid_d    = awid_q;
    aw_idx_d  = aw_idx_q;
    aw_code_d = aw_code_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wlast_d   = wlast_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_code    = RESP_OKAY;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awid_d    = awid;
      aw_idx_d  = awaddr[AW+1:2];
      aw_code_d = resp_code(awaddr, awlen != 8'd0, MEM_WORDS);
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
      wlast_d  = wlast;
    end
    unique case (w_state_q)
      W_COLLECT: begin
        if (aw_held_d && w_held_d) begin
          w_code = aw_code_d;
          if (w_code == RESP_OKAY && !wlast_d) w_code = RESP_SLVERR;
          w_state_d = W_RESP;
          bid_d     = awid_d;
          bresp_d   = w_code;
          mem_we    = (w_code == RESP_OKAY);
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_COLLECT;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awid_q    <= '0;
      aw_idx_q  <= '0;
      aw_code_q <= RESP_OKAY;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awid_q    <= awid_d;
      aw_idx_q  <= aw_idx_d;
      aw_code_q <= aw_code_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wlast_q   <= wlast_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bvalid = (w_state_q == W_RESP);
  assign bid    = bid_q;
  assign bresp  = bresp_q;

  axi_ram_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk     (aclk),
    .rst_n   (aresetn),
    .rd_en   (mem_rd_en),
    .rd_addr (r_idx_q),
    .rd_data (mem_rd_data),
    .wr_en   (mem_we),
    .wr_be   (wstrb_d),
    .wr_addr (aw_idx_d),
    .wr_data (wdata_d)
  );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: vector table, directed corner sequences
// and a randomized phase checked against an array reference model.
module tb_axi_ram_slave;
  import axi_pkg::*;

  localparam int unsigned MW = 4096;
  localparam int unsigned RL = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b1;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  always #5 aclk = ~aclk;

  axi_ram_slave #(.MEM_WORDS(MW), .RD_LAT(RL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [MW];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    int          lead;
    logic [1:0]  exp_b;
    logic [7:0]  rlen;
    logic [1:0]  exp_r;
    logic        chk_d;
    logic [31:0] exp_d;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_resp(input logic [31:0] addr,
    input logic [7:0] len, input logic last);
    if ((addr >> 2) >= MW) return 2'b11;
    if (len != 8'd0 || !last) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [31:0] addr,
    input logic [31:0] data, input logic [3:0] strb);
    int w;
    w = int'(addr >> 2);
    for (int i = 0; i < 4; i++)
      if (strb[i]) model[w][8*i +: 8] = data[8*i +: 8];
  endfunction

  task automatic pulse_reset();
    arvalid = 0; awvalid = 0; wvalid = 0;
    aresetn = 0;
    @(posedge aclk); #1;
    aresetn = 1;
  endtask

  task automatic send_aw_w(input logic [31:0] addr, input logic [7:0] len,
    input logic [31:0] data, input logic [3:0] strb, input logic last,
    input logic [3:0] id, input int lead);
    int t, aw_start, w_start;
    logic aw_done, w_done, awr, wr;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    awaddr = addr; awlen = len; awid = id;
    wdata = data; wstrb = strb; wlast = last; wid = ~id;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 30) begin
      awvalid = !aw_done && (t >= aw_start);
      wvalid  = !w_done && (t >= w_start);
      awr = awready; wr = wready;
      @(posedge aclk); #1;
      if (awvalid && awr) aw_done = 1;
      if (wvalid && wr) w_done = 1;
      t++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL aw_w_timeout: got no handshake, expected one");
    end
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [3:0] id_o);
    int t;
    bready = 1; t = 0;
    while (!bvalid && t < 20) begin
      @(posedge aclk); #1; t++;
    end
    resp = bresp; id_o = bid;
    check("b_seen", 32'(bvalid), 32'd1);
    @(posedge aclk); #1;
    check("b_single", 32'(bvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
    input logic [31:0] data, input logic [3:0] strb, input logic last,
    input logic [3:0] id, input int lead,
    output logic [1:0] resp, output logic [3:0] id_o);
    send_aw_w(addr, len, data, strb, last, id, lead);
    get_b(resp, id_o);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
    input logic [3:0] id, input int hold,
    output logic [31:0] data, output logic [1:0] resp);
    int t, lat;
    logic r;
    araddr = addr; arlen = len; arid = id; rready = 0;
    arvalid = 1; r = 0; t = 0;
    while (!r && t < 20) begin
      r = arready;
      @(posedge aclk); #1; t++;
    end
    arvalid = 0;
    data = '0; resp = '0;
    if (!r) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got no handshake, expected one");
      return;
    end
    lat = 0;
    while (!rvalid && lat < 40) begin
      @(posedge aclk); #1; lat++;
    end
    check("rd_latency", 32'(lat), 32'(RL));
    if (!rvalid) return;
    data = rdata; resp = rresp;
    check("rlast", 32'(rlast), 32'd1);
    check("rid", 32'(rid), 32'(id));
    for (int i = 0; i < hold; i++) begin
      araddr = addr + 32'd4; arvalid = 1;
      check("ar_blocked", 32'(arready), 32'd0);
      @(posedge aclk); #1;
      check("hold_rvalid", 32'(rvalid), 32'd1);
      check("hold_rdata", rdata, data);
      check("hold_rid", 32'(rid), 32'(id));
      check("hold_rresp", 32'(rresp), 32'(resp));
    end
    arvalid = 0;
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    check("r_single", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  rs, bs;
    logic [3:0]  bi;
    logic        seen;

    vecs[0] = '{32'h40, 8'd0, 32'h12345678, 4'hF, 1'b1, 0,
                2'b00, 8'd0, 2'b00, 1'b1, 32'h12345678};
    vecs[1] = '{32'h40, 8'd0, 32'hAABBCCDD, 4'h8, 1'b1, -2,
                2'b00, 8'd0, 2'b00, 1'b1, 32'hAA345678};
    vecs[2] = '{32'h40, 8'd0, 32'h00000000, 4'h0, 1'b1, 1,
                2'b00, 8'd0, 2'b00, 1'b1, 32'hAA345678};
    vecs[3] = '{32'h40, 8'd2, 32'hFFFFFFFF, 4'hF, 1'b1, 0,
                2'b10, 8'd0, 2'b00, 1'b1, 32'hAA345678};
    vecs[4] = '{32'h40, 8'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 2,
                2'b10, 8'd3, 2'b10, 1'b0, 32'h0};
    vecs[5] = '{32'h3FFC, 8'd0, 32'hCAFEF00D, 4'hF, 1'b1, 0,
                2'b00, 8'd0, 2'b00, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{32'h4000, 8'd0, 32'h00000001, 4'hF, 1'b1, 0,
                2'b11, 8'd0, 2'b11, 1'b1, 32'h0};
    vecs[7] = '{32'h00010000, 8'd0, 32'h55555555, 4'hF, 1'b1, -1,
                2'b11, 8'd0, 2'b11, 1'b1, 32'h0};
    vecs[8] = '{32'h40, 8'd0, 32'h11223344, 4'h6, 1'b1, 0,
                2'b00, 8'd0, 2'b00, 1'b1, 32'hAA223378};

    repeat (2) @(posedge aclk);
    #1;
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {28'd0, rresp, bresp}, 32'd0);
    check("rst_ids", {24'd0, rid, bid}, 32'd0);
    aresetn = 1;
    @(posedge aclk); #1;

    // Read latency with a preloaded word
    do_write(32'h10, 8'd0, 32'hDEADBEEF, 4'hF, 1'b1, 4'd1, 0, bs, bi);
    check("pre4_bresp", 32'(bs), 32'd0);
    do_read(32'h10, 8'd0, 4'd5, 0, d, rs);
    check("r22_rdata", d, 32'hDEADBEEF);
    check("r22_rresp", 32'(rs), 32'd0);

    // W leads AW by two cycles with partial strobes
    do_write(32'h20, 8'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd2, 0, bs, bi);
    do_write(32'h20, 8'd0, 32'h11223344, 4'b0101, 1'b1, 4'd9, 2, bs, bi);
    check("r23_bresp", 32'(bs), 32'd0);
    check("r23_bid", 32'(bi), 32'd9);
    do_read(32'h20, 8'd0, 4'd3, 0, d, rs);
    check("r23_rdata", d, 32'hFF22FF44);

    // Backpressure on R for five cycles
    do_read(32'h10, 8'd0, 4'hC, 5, d, rs);
    check("r24_rdata", d, 32'hDEADBEEF);

    // Vector table
    do_write(32'h0, 8'd0, 32'h0BADF00D, 4'hF, 1'b1, 4'd0, 0, bs, bi);
    for (int i = 0; i < NV; i++) begin
      do_write(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].strb,
               vecs[i].last, 4'(i), vecs[i].lead, bs, bi);
      check($sformatf("vec%0d_bresp", i), 32'(bs), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d_bid", i), 32'(bi), 32'(i));
      do_read(vecs[i].addr, vecs[i].rlen, 4'(i + 1), i % 3, d, rs);
      check($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].exp_r));
      if (vecs[i].chk_d)
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_d);
    end
    do_read(32'h0, 8'd0, 4'd7, 0, d, rs);
    check("r25_alias_unchanged", d, 32'h0BADF00D);

    // Same-cycle read sample and write commit to word 8
    do_write(32'h20, 8'd0, 32'h0000000A, 4'hF, 1'b1, 4'd1, 0, bs, bi);
    araddr = 32'h20; arlen = 0; arid = 4'd6; rready = 0; arvalid = 1;
    @(posedge aclk); #1;
    arvalid = 0;
    repeat (2) begin @(posedge aclk); #1; end
    awaddr = 32'h20; awlen = 0; awid = 4'd4;
    wdata = 32'h0000000B; wstrb = 4'hF; wlast = 1;
    awvalid = 1; wvalid = 1; bready = 0;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    check("r26_rvalid", 32'(rvalid), 32'd1);
    check("r26_bvalid", 32'(bvalid), 32'd1);
    check("r26_rdata_old", rdata, 32'h0000000A);
    rready = 1; bready = 1;
    @(posedge aclk); #1;
    rready = 0;
    do_read(32'h20, 8'd0, 4'd2, 0, d, rs);
    check("r26_rdata_new", d, 32'h0000000B);

    // Reset during R_WAIT
    araddr = 32'h10; arlen = 0; arid = 4'd8; arvalid = 1;
    @(posedge aclk); #1;
    arvalid = 0;
    pulse_reset();
    rready = 1; seen = 0;
    repeat (6) begin
      if (rvalid) seen = 1;
      @(posedge aclk); #1;
    end
    rready = 0;
    check("r27_no_rvalid", 32'(seen), 32'd0);
    check("r27_readies_r", {29'd0, arready, awready, wready}, 32'd7);

    // Reset during W_RESP
    bready = 0;
    send_aw_w(32'h24, 8'd0, 32'h77777777, 4'hF, 1'b1, 4'd3, 0);
    check("r27_bvalid_pre", 32'(bvalid), 32'd1);
    pulse_reset();
    bready = 1; seen = 0;
    repeat (6) begin
      if (bvalid) seen = 1;
      @(posedge aclk); #1;
    end
    check("r27_no_bvalid", 32'(seen), 32'd0);
    check("r27_readies_w", {29'd0, arready, awready, wready}, 32'd7);
    do_read(32'h24, 8'd0, 4'd1, 0, d, rs);
    check("r27_mem_kept", d, 32'h77777777);

    // Randomized phase against the array model
    for (int w = 32; w < 64; w++) begin
      d = $urandom;
      do_write(32'(w) << 2, 8'd0, d, 4'hF, 1'b1, 4'd0, 0, bs, bi);
      model[w] = d;
    end
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a, dat;
      logic [7:0]  ln;
      logic [3:0]  st, id;
      logic        lst;
      int          w;
      w   = 32 + int'($urandom_range(0, 31));
      a   = 32'(w) << 2;
      ln  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      id  = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom;
        st  = 4'($urandom);
        lst = ($urandom_range(0, 5) != 0);
        do_write(a, ln, dat, st, lst, id,
                 int'($urandom_range(0, 4)) - 2, bs, bi);
        check("rnd_bresp", 32'(bs), 32'(ref_resp(a, ln, lst)));
        check("rnd_bid", 32'(bi), 32'(id));
        if (ref_resp(a, ln, lst) == 2'b00) model_write(a, dat, st);
      end else begin
        do_read(a, ln, id, int'($urandom_range(0, 3)), d, rs);
        check("rnd_rresp", 32'(rs), 32'(ref_resp(a, ln, 1'b1)));
        if (ln == 8'd0) check("rnd_rdata", d, model[w]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
